// File: rtl/cache_2way_wb_ctrl.sv
`default_nettype none
//==============================================================================
// Module   : cache_2way_wb_ctrl
// Brief    : Two-way set-associative, write-back, write-allocate data cache
//            controller. 32-bit CPU word port, 128-bit memory block port,
//            per-set LRU replacement and saturating hit/miss statistics.
// Revision : 1.0 - initial release
//==============================================================================
module cache_2way_wb_ctrl #(
  parameter int SET_BITS = 1,
  parameter int MEM_LAT  = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         cpu_req,
  input  logic         cpu_we,
  input  logic [9:0]   cpu_addr,
  input  logic [31:0]  cpu_wdata,
  output logic [31:0]  cpu_rdata,
  output logic         cpu_ready,
  output logic         mem_write,
  output logic [9:0]   mem_addr,
  output logic [127:0] mem_wdata,
  input  logic [127:0] mem_rdata,
  output logic [15:0]  hit_count,
  output logic [15:0]  miss_count
);

  localparam int         c_numSets = 2 ** SET_BITS;
  localparam int         c_tagW    = 6 - SET_BITS;
  localparam logic [3:0] c_latLoad = 4'(MEM_LAT - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    COMPARE   = 2'd1,
    WRITEBACK = 2'd2,
    ALLOCATE  = 2'd3
  } state_t;

  state_t r_state;
  state_t w_nextState;

  // Cache storage: per set and way; one LRU bit per set names the victim way
  logic              r_valid [c_numSets][2];
  logic              r_dirty [c_numSets][2];
  logic [c_tagW-1:0] r_tag   [c_numSets][2];
  logic [127:0]      r_data  [c_numSets][2];
  logic              r_lru   [c_numSets];

  // Latched request and transaction bookkeeping
  logic [9:2]  r_reqAddr;
  logic        r_reqWe;
  logic [31:0] r_reqWdata;
  logic        r_victim;
  logic        r_retry;
  logic [3:0]  r_cnt;

  logic [SET_BITS-1:0] w_index;
  logic [c_tagW-1:0]   w_tag;
  logic [1:0]          w_word;
  logic                w_hit0;
  logic                w_hit1;
  logic                w_hit;
  logic                w_hitWay;
  logic                w_victim;
  logic                w_victimDirty;
  logic                w_start;
  logic                w_fill;
  logic [127:0]        w_hitBlock;
  logic [127:0]        w_mergedBlock;
  logic [31:0]         w_hitWord;
  logic                w_unusedAddrLsbs;

  // Byte offset within a word carries no information for word accesses
  assign w_unusedAddrLsbs = ^cpu_addr[1:0];

  assign w_index = r_reqAddr[4 +: SET_BITS];
  assign w_tag   = r_reqAddr[9 -: c_tagW];
  assign w_word  = r_reqAddr[3:2];

  assign w_hit0   = r_valid[w_index][0] && (r_tag[w_index][0] == w_tag);
  assign w_hit1   = r_valid[w_index][1] && (r_tag[w_index][1] == w_tag);
  assign w_hit    = w_hit0 || w_hit1;
  assign w_hitWay = w_hit1;

  // Fill an empty way first (way 0 preferred); only evict when the set is full
  assign w_victim = !r_valid[w_index][0] ? 1'b0 :
                    !r_valid[w_index][1] ? 1'b1 : r_lru[w_index];
  assign w_victimDirty = r_valid[w_index][w_victim] && r_dirty[w_index][w_victim];

  // A completion pulse masks cpu_req so a held request is not re-issued early
  assign w_start = (r_state == IDLE) && cpu_req && !cpu_ready;
  assign w_fill  = (r_state == ALLOCATE) && (r_cnt == 4'd0);

  assign w_hitBlock = r_data[w_index][w_hitWay];

  // Select the addressed word and build the store-merged block (word 0 is MSB)
  always_comb begin
    w_hitWord     = w_hitBlock[127:96];
    w_mergedBlock = w_hitBlock;
    case (w_word)
      2'd0: begin
        w_hitWord             = w_hitBlock[127:96];
        w_mergedBlock[127:96] = r_reqWdata;
      end
      2'd1: begin
        w_hitWord            = w_hitBlock[95:64];
        w_mergedBlock[95:64] = r_reqWdata;
      end
      2'd2: begin
        w_hitWord            = w_hitBlock[63:32];
        w_mergedBlock[63:32] = r_reqWdata;
      end
      default: begin
        w_hitWord           = w_hitBlock[31:0];
        w_mergedBlock[31:0] = r_reqWdata;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic; writeback length is tracked by the registered mem_write
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: begin
        if (w_start) w_nextState = COMPARE;
      end
      COMPARE: begin
        if (w_hit)              w_nextState = IDLE;
        else if (w_victimDirty) w_nextState = WRITEBACK;
        else                    w_nextState = ALLOCATE;
      end
      WRITEBACK: begin
        if (!mem_write) w_nextState = ALLOCATE;
      end
      ALLOCATE: begin
        if (r_cnt == 4'd0) w_nextState = COMPARE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Registered outputs, request latch, statistics and memory-side sequencing
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cpu_ready  <= 1'b0;
      cpu_rdata  <= '0;
      mem_write  <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      hit_count  <= '0;
      miss_count <= '0;
      r_reqAddr  <= '0;
      r_reqWe    <= 1'b0;
      r_reqWdata <= '0;
      r_victim   <= 1'b0;
      r_retry    <= 1'b0;
      r_cnt      <= '0;
    end else begin
      cpu_ready <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_reqAddr  <= cpu_addr[9:2];
            r_reqWe    <= cpu_we;
            r_reqWdata <= cpu_wdata;
            r_retry    <= 1'b0;
          end
        end
        COMPARE: begin
          if (w_hit) begin
            cpu_ready <= 1'b1;
            if (!r_reqWe) cpu_rdata <= w_hitWord;
            // The lookup that follows a refill is part of the miss, not a hit
            if (!r_retry && (hit_count != 16'hFFFF)) hit_count <= hit_count + 16'd1;
          end else begin
            if (miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;
            r_victim <= w_victim;
            if (w_victimDirty) begin
              mem_write <= 1'b1;
              mem_addr  <= {r_tag[w_index][w_victim], w_index, 4'b0000};
              mem_wdata <= r_data[w_index][w_victim];
            end else begin
              mem_write <= 1'b0;
              mem_addr  <= {w_tag, w_index, 4'b0000};
              r_cnt     <= c_latLoad;
            end
          end
        end
        WRITEBACK: begin
          // Memory latches on the 1->0 edge, so address/data hold for both cycles
          mem_write <= 1'b0;
          if (!mem_write) begin
            mem_addr <= {w_tag, w_index, 4'b0000};
            r_cnt    <= c_latLoad;
          end
        end
        ALLOCATE: begin
          if (r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
          else               r_retry <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Valid/dirty/LRU bookkeeping; cleared on reset so dirty data is discarded
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < c_numSets; s++) begin
        r_lru[s] <= 1'b0;
        for (int w = 0; w < 2; w++) begin
          r_valid[s][w] <= 1'b0;
          r_dirty[s][w] <= 1'b0;
        end
      end
    end else begin
      if ((r_state == COMPARE) && w_hit) begin
        r_lru[w_index] <= ~w_hitWay;
        if (r_reqWe) r_dirty[w_index][w_hitWay] <= 1'b1;
      end
      if (w_fill) begin
        r_valid[w_index][r_victim] <= 1'b1;
        r_dirty[w_index][r_victim] <= 1'b0;
      end
    end
  end

  // Tag and data arrays: meaningful only where valid, so they carry no reset
  always_ff @(posedge clk) begin
    if ((r_state == COMPARE) && w_hit && r_reqWe) begin
      r_data[w_index][w_hitWay] <= w_mergedBlock;
    end
    if (w_fill) begin
      r_data[w_index][r_victim] <= mem_rdata;
      r_tag[w_index][r_victim]  <= w_tag;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cache_2way_wb_ctrl.sv
`default_nettype none
//==============================================================================
// Module   : tb_cache_2way_wb_ctrl
// Brief    : Self-checking bench for cache_2way_wb_ctrl. A block-level cache
//            model (block numbers, plain arrays) predicts latency, memory
//            traffic, read data and statistics for every request.
// Revision : 1.0 - initial release
//==============================================================================
module tb_cache_2way_wb_ctrl;

  localparam int SB    = 1;
  localparam int ML    = 4;
  localparam int NSETS = 2 ** SB;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         cpu_req = 1'b0;
  logic         cpu_we = 1'b0;
  logic [9:0]   cpu_addr = '0;
  logic [31:0]  cpu_wdata = '0;
  logic [31:0]  cpu_rdata;
  logic         cpu_ready;
  logic         mem_write;
  logic [9:0]   mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata;
  logic [15:0]  hit_count;
  logic [15:0]  miss_count;

  int total = 0;
  int bad   = 0;

  cache_2way_wb_ctrl #(.SET_BITS(SB), .MEM_LAT(ML)) dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_ready (cpu_ready),
    .mem_write (mem_write),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .hit_count (hit_count),
    .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  // Initial memory image; a few words are fixed so directed results are known
  function automatic logic [127:0] initBlock(int b);
    logic [31:0] x [4];
    for (int w = 0; w < 4; w++) x[w] = 32'(b * 4 + w + 1) * 32'h9E3779B1;
    if (b == 0) begin
      x[0] = 32'hAE252530; x[1] = 32'hFBE41EA3; x[3] = 32'hA19D33D0;
    end
    if (b == 4) x[0] = 32'hABF01A90;
    return {x[0], x[1], x[2], x[3]};
  endfunction

  // Main memory: combinational read, block write while mem_write is high
  logic [127:0] memArr [64];
  bit           memLoaded = 1'b0;
  assign mem_rdata = memArr[mem_addr[9:4]];

  always @(posedge clk) begin
    if (!memLoaded) begin
      for (int b = 0; b < 64; b++) memArr[b] <= initBlock(b);
      memLoaded <= 1'b1;
    end else if (mem_write) begin
      memArr[mem_addr[9:4]] <= mem_wdata;
    end
  end

  // ---------------- behavioural model ----------------
  logic [127:0] refMem [64];
  bit           mV     [NSETS][2];
  bit           mD     [NSETS][2];
  int           mBlkNo [NSETS][2];
  logic [127:0] mData  [NSETS][2];
  int           mLru   [NSETS];
  logic [15:0]  mHits, mMiss;

  int           eKind;      // 0 hit, 1 clean miss, 2 dirty miss
  int           eLat;
  logic [31:0]  eRdata;
  logic [9:0]   eWbAddr, eAllocAddr;
  logic [127:0] eWbData;

  function automatic logic [31:0] getWord(logic [127:0] b, int w);
    return b[127 - 32 * w -: 32];
  endfunction

  function automatic logic [127:0] setWord(logic [127:0] b, int w, logic [31:0] v);
    logic [127:0] r = b;
    r[127 - 32 * w -: 32] = v;
    return r;
  endfunction

  task automatic modelReset();
    for (int s = 0; s < NSETS; s++) begin
      mLru[s] = 0;
      for (int w = 0; w < 2; w++) begin
        mV[s][w] = 1'b0; mD[s][w] = 1'b0; mBlkNo[s][w] = -1;
      end
    end
    mHits = '0; mMiss = '0; eRdata = '0;
  endtask

  task automatic modelReq(bit we, logic [9:0] addr, logic [31:0] wdata);
    int blk = int'(addr[9:4]);
    int s   = blk % NSETS;
    int w   = int'(addr[3:2]);
    int way = -1;
    for (int i = 0; i < 2; i++) if (mV[s][i] && mBlkNo[s][i] == blk) way = i;
    eAllocAddr = 10'(blk * 16);
    if (way >= 0) begin
      eKind = 0; eLat = 2;
      if (mHits != 16'hFFFF) mHits = mHits + 16'd1;
    end else begin
      if (mMiss != 16'hFFFF) mMiss = mMiss + 16'd1;
      way = !mV[s][0] ? 0 : (!mV[s][1] ? 1 : mLru[s]);
      if (mV[s][way] && mD[s][way]) begin
        eKind = 2; eLat = 5 + ML;
        eWbAddr = 10'(mBlkNo[s][way] * 16);
        eWbData = mData[s][way];
        refMem[mBlkNo[s][way]] = mData[s][way];
      end else begin
        eKind = 1; eLat = 3 + ML;
      end
      mData[s][way] = refMem[blk]; mBlkNo[s][way] = blk;
      mV[s][way] = 1'b1; mD[s][way] = 1'b0;
    end
    if (we) begin
      mData[s][way] = setWord(mData[s][way], w, wdata);
      mD[s][way] = 1'b1;
    end else begin
      eRdata = getWord(mData[s][way], w);
    end
    mLru[s] = 1 - way;
  endtask

  // ---------------- checking ----------------
  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic checkZeros(string tag);
    chk({tag, "_ready"}, cpu_ready, 0);
    chk({tag, "_mem_write"}, mem_write, 0);
    chk({tag, "_rdata"}, cpu_rdata, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_mem_wdata"}, mem_wdata, 0);
    chk({tag, "_hit_count"}, hit_count, 0);
    chk({tag, "_miss_count"}, miss_count, 0);
  endtask

  // Per-cycle comparison; t counts cycles after the request was sampled
  task automatic checkCycle(int t);
    int allocStart = (eKind == 2) ? 4 : 2;
    chk("cpu_ready", cpu_ready, (t == eLat));
    chk("mem_write", mem_write, (eKind == 2 && t == 2));
    if (eKind == 2 && (t == 2 || t == 3)) begin
      chk("wb_mem_addr", mem_addr, eWbAddr);
      chk("wb_mem_wdata", mem_wdata, eWbData);
    end
    if (eKind != 0 && t >= allocStart && t < allocStart + ML)
      chk("alloc_mem_addr", mem_addr, eAllocAddr);
    if (t == eLat) begin
      chk("cpu_rdata", cpu_rdata, eRdata);
      chk("hit_count", hit_count, mHits);
      chk("miss_count", miss_count, mMiss);
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    reset = 1'b1; cpu_req = 1'b0;
    repeat (2) @(negedge clk);
    checkZeros("reset");
    reset = 1'b0;
    modelReset();
  endtask

  // Issue one request; abortAt > 0 fires an async reset in that cycle
  task automatic doReq(bit we, logic [9:0] addr, logic [31:0] wdata, int abortAt);
    int  dropAt;
    bit  aborted = 1'b0;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    modelReq(we, addr, wdata);
    dropAt = int'($urandom_range(1, eLat));
    for (int t = 1; t <= eLat; t++) begin
      @(negedge clk);
      checkCycle(t);
      if (t == abortAt) begin
        #1 reset = 1'b1;
        #1 checkZeros("async_reset");
        @(negedge clk);
        reset = 1'b0; cpu_req = 1'b0;
        modelReset();
        aborted = 1'b1;
        break;
      end
      if (t == dropAt) begin
        cpu_req = 1'b0; cpu_we = 1'($urandom);
        cpu_addr = 10'($urandom); cpu_wdata = $urandom;
      end
    end
    if (!aborted) begin
      cpu_req = 1'b0;
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        chk("idle_ready", cpu_ready, 0);
        chk("idle_mem_write", mem_write, 0);
      end
    end
  endtask

  logic [127:0] expBlk0;

  initial begin
    for (int b = 0; b < 64; b++) refMem[b] = initBlock(b);
    modelReset();
    doReset();

    // Directed sequence with hand-computed expectations
    doReq(1'b0, 10'h004, 32'h0, 0);
    chk("cold_rdata_lit", cpu_rdata, 32'hFBE41EA3);
    chk("cold_miss_lit", miss_count, 16'd1);
    chk("cold_hit_lit", hit_count, 16'd0);
    doReq(1'b0, 10'h004, 32'h0, 0);
    chk("hit_rdata_lit", cpu_rdata, 32'hFBE41EA3);
    chk("hit_count_lit", hit_count, 16'd1);
    doReq(1'b1, 10'h008, 32'h12345678, 0);
    doReq(1'b0, 10'h008, 32'h0, 0);
    chk("store_rdata_lit", cpu_rdata, 32'h12345678);
    chk("store_hits_lit", hit_count, 16'd3);
    doReq(1'b0, 10'h020, 32'h0, 0);
    doReq(1'b0, 10'h040, 32'h0, 0);
    chk("evict_kind_lit", eKind, 2);
    chk("evict_rdata_lit", cpu_rdata, 32'hABF01A90);
    expBlk0 = {32'hAE252530, 32'hFBE41EA3, 32'h12345678, 32'hA19D33D0};
    chk("wb_memory_lit", memArr[0], expBlk0);
    doReq(1'b0, 10'h008, 32'h0, 0);
    chk("reload_kind_lit", eKind, 1);
    chk("reload_rdata_lit", cpu_rdata, 32'h12345678);

    // Randomised traffic over 8 blocks spanning both sets
    for (int n = 0; n < 150; n++) begin
      logic [5:0] blk = 6'($urandom_range(0, 7));
      logic [1:0] wd  = 2'($urandom);
      logic [1:0] lo  = 2'($urandom);
      doReq(1'($urandom), {blk, wd, lo}, $urandom, 0);
    end

    // Reset in the second ALLOCATE cycle discards the transaction and the cache
    doReset();
    doReq(1'b0, 10'h004, 32'h0, 3);
    doReq(1'b0, 10'h004, 32'h0, 0);
    chk("post_abort_kind_lit", eKind, 1);
    chk("post_abort_miss_lit", miss_count, 16'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cache_2way_wb_ctrl.md
Name: cache_2way_wb_ctrl

Overview:
- Two-way set-associative, write-back, write-allocate data cache and its controller.
- Sits between the CPU load/store stage and the 1 KB block-organised main memory.
- Serves 32-bit word requests from the CPU.
- Exchanges 128-bit (4-word) blocks with memory.
- Uses per-set LRU replacement and keeps hit/miss statistics.

Parameters:
- SET_BITS, 1, index width. Number of sets = 2**SET_BITS. Tag = addr[9:4+SET_BITS].
- MEM_LAT, 4, cycles spent in ALLOCATE waiting for memory read data. Legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- cpu_req  in  1  request valid. Level signal, held until cpu_ready is seen.
- cpu_we  in  1  1 = store, 0 = load.
- cpu_addr  in  10  byte address. Word offset = addr[3:2]; addr[1:0] is ignored.
- cpu_wdata  in  32  store data.
- cpu_rdata  out  32  load data. Valid while cpu_ready = 1; held until the next completion.
- cpu_ready  out  1  one-cycle completion pulse.
- mem_write  out  1  drives the memory ReadOrWrite input. 1 = write block.
- mem_addr  out  10  block address to memory. Bits [3:0] are always 0.
- mem_wdata  out  128  block to write. Word 0 in bits [127:96], word 3 in bits [31:0].
- mem_rdata  in  128  block read from memory, same word ordering as mem_wdata. Memory returns it combinationally for mem_addr.
- hit_count  out  16  saturating count of COMPARE hits on first lookup.
- miss_count  out  16  saturating count of misses.

Behaviour:
- Storage per set and way: valid, dirty, tag, 128-bit data. One LRU bit per set, naming the least-recently-used way.
- All outputs are registered.
- Reset (async) effects:
  - state = IDLE.
  - All valid, dirty and LRU bits cleared.
  - cpu_ready, mem_write, cpu_rdata, mem_addr, mem_wdata, hit_count and miss_count all = 0.
  - Dirty data is discarded with no write-back, including when reset hits mid-operation.
- IDLE:
  - If cpu_req = 1 and cpu_ready = 0, latch addr/we/wdata and go to COMPARE.
  - cpu_req is ignored in the cycle cpu_ready = 1.
  - A request still high in the following cycle is a new request.
- COMPARE:
  - hit = valid & tag match in either way. Both ways matching cannot occur.
  - Hit, load: cpu_rdata <= selected word.
  - Hit, store: merge wdata into word addr[3:2] and set dirty.
  - Hit, either case: LRU <= other way; cpu_ready = 1 next cycle; go to IDLE. The retry hit after a refill is not counted in hit_count.
  - Miss: miss_count++. Victim = first invalid way (way 0 preferred), else the LRU way.
  - Victim valid and dirty: go to WRITEBACK. Otherwise go to ALLOCATE.
- WRITEBACK (2 cycles):
  - mem_addr = {victim tag, index, 4'b0} and mem_wdata = victim block, both stable for both cycles.
  - mem_write = 1 in the first cycle, 0 in the second; memory latches on the level change.
  - Then go to ALLOCATE.
- ALLOCATE (MEM_LAT cycles):
  - mem_write = 0 and mem_addr = {req tag, index, 4'b0}.
  - A down-counter runs from MEM_LAT-1 to 0.
  - At 0: victim data <= mem_rdata, tag <= req tag, valid = 1, dirty = 0. Go to COMPARE; this second lookup hits and completes the request, including any store merge.
- Latency, with req sampled in IDLE at cycle k:
  - Hit: cpu_ready at k+2.
  - Clean miss: cpu_ready at k+3+MEM_LAT.
  - Dirty miss: cpu_ready at k+5+MEM_LAT.
- Counters saturate at 16'hFFFF.
- cpu_req deasserted mid-transaction has no effect; the transaction completes.

Test Plan:
- Cold read: reset, then load 0x004 with MEM_LAT = 4.
  - ALLOCATE shows mem_addr = 0x000.
  - cpu_ready at k+7, cpu_rdata = 0xFBE41EA3, miss_count = 1, mem_write never 1.
- Hit: load 0x004 again.
  - cpu_ready at k+2, rdata 0xFBE41EA3, hit_count = 1, no memory activity.
- Store hit: store 0x12345678 to 0x008, then load 0x008.
  - Both hit; rdata 0x12345678; mem_write stays 0.
- Dirty eviction: load 0x020 (fills way 1, LRU -> way 0), then load 0x040.
  - WRITEBACK: mem_addr = 0x000, mem_wdata = {AE252530, FBE41EA3, 12345678, A19D33D0}, mem_write = 1 for exactly one cycle.
  - ALLOCATE: mem_addr = 0x040.
  - rdata 0xABF01A90 at k+9.
- Write-back check: load 0x008.
  - Miss that evicts clean way 1 (0x020); no WRITEBACK.
  - rdata 0x12345678, proving memory was updated.
- Reset mid-ALLOCATE: assert reset in the 2nd ALLOCATE cycle.
  - Outputs 0 immediately, with no clock edge needed.
  - A following load 0x004 is a miss (miss_count = 1).
